// File: rtl/fxyz_pkg.sv
// fxyz_pkg: shared types and constants for the fxyz truth-table sweeper.
//   state_e : sweep FSM states
//   vec_t   : {X,Y,Z} vector index
//   tt_t    : packed truth table, bit i = F at vector i
package fxyz_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;

  typedef logic [VEC_W-1:0]       vec_t;
  typedef logic [NUM_VECTORS-1:0] tt_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/fxyz_hold_timer.sv
// fxyz_hold_timer: settle counter for one sweep vector.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : restart the settle window (asserted on the edge entering DRIVE)
//   expired : high during the last of HOLD_CYCLES settle cycles
module fxyz_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("fxyz_hold_timer: HOLD_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] Last = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Saturates at Last so an idle timer never wraps back into a false window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q != Last) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (cnt_q == Last);

endmodule

// File: rtl/fxyz_sweep.sv
// fxyz_sweep: drives X,Y,Z through all 8 vectors in ascending order, lets each settle
// HOLD_CYCLES cycles, samples F once per vector and packs the results into truth_table.
//   clk, rst    : clock, synchronous active-high reset
//   start       : sweep request, accepted only in IDLE
//   F           : output of the downstream fxyz block
//   X, Y, Z     : fxyz inputs, {X,Y,Z} = vector index (registered)
//   busy        : high in DRIVE and SAMPLE
//   done        : one-cycle pulse in the DONE cycle
//   truth_table : bit i = F sampled with {X,Y,Z} = i
//   table_valid : truth_table holds a complete sweep
//   mismatch    : final table != EXPECTED (only with FXYZ_SWEEP_CHECK_EN defined)
// Optional feature macro: FXYZ_SWEEP_CHECK_EN.
module fxyz_sweep
  import fxyz_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [7:0]  EXPECTED    = 8'h96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       F,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       table_valid
`ifdef FXYZ_SWEEP_CHECK_EN
  ,
  output logic       mismatch
`endif
);

  localparam vec_t LastIdx = VEC_W'(NUM_VECTORS - 1);

  state_e state_q;
  vec_t   idx_q;
  vec_t   xyz_q;
  logic   busy_q;
  logic   done_q;
  tt_t    tt_q;
  logic   valid_q;
  logic   timer_clear;
  logic   expired;

  // Restart the settle window on every edge that enters DRIVE.
  assign timer_clear = ((state_q == IDLE) && start) ||
                       ((state_q == SAMPLE) && (idx_q != LastIdx));

  fxyz_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .expired(expired)
  );

`ifdef FXYZ_SWEEP_CHECK_EN
  logic mismatch_q;
  tt_t  tt_final;

  // Table as it will be once the last sample lands; compared on the edge entering DONE
  // so mismatch is already valid alongside the done pulse.
  always_comb begin
    tt_final        = tt_q;
    tt_final[idx_q] = F;
  end
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      xyz_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_q       <= '0;
      valid_q    <= 1'b0;
`ifdef FXYZ_SWEEP_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= DRIVE;
            idx_q      <= '0;
            xyz_q      <= '0;
            busy_q     <= 1'b1;
            tt_q       <= '0;
            valid_q    <= 1'b0;
`ifdef FXYZ_SWEEP_CHECK_EN
            mismatch_q <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (expired) state_q <= SAMPLE;
        end
        SAMPLE: begin
          tt_q[idx_q] <= F;
          if (idx_q == LastIdx) begin
            state_q    <= DONE;
            xyz_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            valid_q    <= 1'b1;
`ifdef FXYZ_SWEEP_CHECK_EN
            mismatch_q <= (tt_final != EXPECTED);
`endif
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_q + VEC_W'(1);
            xyz_q   <= idx_q + VEC_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {X, Y, Z}   = xyz_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign table_valid = valid_q;
`ifdef FXYZ_SWEEP_CHECK_EN
  assign mismatch    = mismatch_q;
`endif

endmodule

// File: tb/tb_fxyz_sweep.sv
// tb_fxyz_sweep: two sweepers (HOLD_CYCLES 2 and 1) share rst/start and each drives its own
// F = ftab[{X,Y,Z}]. A cycle-count model predicts every output each cycle; directed
// literal checks pin the model on the headline cases.
module tb_fxyz_sweep;

  localparam int H0 = 2;
  localparam int H1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ftab;
  logic       chk_en = 1'b0;

  logic x0, y0, z0, busy0, done0, tv0, f0;
  logic x1, y1, z1, busy1, done1, tv1, f1;
  logic [7:0] tt0, tt1;
  logic mis0, mis1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign f0 = ftab[{x0, y0, z0}];
  assign f1 = ftab[{x1, y1, z1}];

  fxyz_sweep #(.HOLD_CYCLES(H0), .EXPECTED(8'h96)) dut (
    .clk(clk), .rst(rst), .start(start), .F(f0),
    .X(x0), .Y(y0), .Z(z0), .busy(busy0), .done(done0),
    .truth_table(tt0), .table_valid(tv0)
`ifdef FXYZ_SWEEP_CHECK_EN
    , .mismatch(mis0)
`endif
  );

  fxyz_sweep #(.HOLD_CYCLES(H1), .EXPECTED(8'h96)) dut1 (
    .clk(clk), .rst(rst), .start(start), .F(f1),
    .X(x1), .Y(y1), .Z(z1), .busy(busy1), .done(done1),
    .truth_table(tt1), .table_valid(tv1)
`ifdef FXYZ_SWEEP_CHECK_EN
    , .mismatch(mis1)
`endif
  );

`ifndef FXYZ_SWEEP_CHECK_EN
  assign mis0 = 1'b0;
  assign mis1 = 1'b0;
`endif

  // Model: t = cycles since start acceptance (0 = idle); vector v owns cycles
  // v*(H+1)+1 .. (v+1)*(H+1), sampled in the last; DONE is cycle 8*(H+1)+1.
  int         m_t[2];
  logic [7:0] m_tbl[2];
  logic       m_val[2];
  logic       m_mis[2];

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int h, n, t, v;
      logic [7:0] tb;
      logic va, mi;
      h = hold_of(i);
      n = 8 * (h + 1) + 1;
      t = m_t[i]; tb = m_tbl[i]; va = m_val[i]; mi = m_mis[i];
      if (rst) begin
        t = 0; tb = 8'h00; va = 1'b0; mi = 1'b0;
      end else if (t == 0) begin
        if (start) begin
          t = 1; tb = 8'h00; va = 1'b0; mi = 1'b0;
        end
      end else if (t == n) begin
        t = 0;
      end else begin
        if (t % (h + 1) == 0) begin
          v = t / (h + 1) - 1;
          tb[v] = ftab[v];
        end
        t++;
        if (t == n) begin
          va = 1'b1;
          mi = (tb != 8'h96);
        end
      end
      m_t[i] <= t; m_tbl[i] <= tb; m_val[i] <= va; m_mis[i] <= mi;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic check_inst(input int i, input logic [2:0] xyz, input logic b, input logic d,
                            input logic [7:0] tt, input logic v, input logic m);
    int h, n, t;
    logic eb;
    h = hold_of(i);
    n = 8 * (h + 1) + 1;
    t = m_t[i];
    eb = (t >= 1) && (t < n);
    check($sformatf("dut%0d.xyz", i), {29'd0, xyz}, eb ? 32'((t - 1) / (h + 1)) : 32'd0);
    check($sformatf("dut%0d.busy", i), {31'd0, b}, {31'd0, eb});
    check($sformatf("dut%0d.done", i), {31'd0, d}, {31'd0, t == n});
    check($sformatf("dut%0d.table", i), {24'd0, tt}, {24'd0, m_tbl[i]});
    check($sformatf("dut%0d.valid", i), {31'd0, v}, {31'd0, m_val[i]});
`ifdef FXYZ_SWEEP_CHECK_EN
    check($sformatf("dut%0d.mismatch", i), {31'd0, m}, {31'd0, m_mis[i]});
`else
    if (m !== 1'b0) check("mismatch_tie", {31'd0, m}, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, {x0, y0, z0}, busy0, done0, tt0, tv0, mis0);
      check_inst(1, {x1, y1, z1}, busy1, done1, tt1, tv1, mis1);
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (m_t[0] == 0 && m_t[1] == 0 && !busy0 && !busy1) break;
      @(negedge clk);
    end
    check("wait_idle", {30'd0, busy0, busy1}, 32'd0);
  endtask

  task automatic sweep();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int dk0, dk1, nd0;
    rst   = 1'b1;
    start = 1'b0;
    ftab  = 8'h96;  // F = X^Y^Z
    @(negedge clk);
    chk_en = 1'b1;
    check("rst.table", {24'd0, tt0}, 32'h00);
    check("rst.busy_valid", {30'd0, busy0, tv0}, 32'd0);
    check("rst.xyz", {29'd0, x0, y0, z0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single pulse with ignored re-pulses at cycles 5, 24 and the DONE cycle 25.
    dk0 = -1; dk1 = -1; nd0 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done0) begin
        nd0++;
        if (dk0 < 0) dk0 = k;
      end
      if (done1 && dk1 < 0) dk1 = k;
      if (k == 1)  check("t1.busy_c1", {31'd0, busy0}, 32'd1);
      if (k == 24) check("t1.busy_c24", {31'd0, busy0}, 32'd1);
      if (k == 25) check("t1.valid_c25", {31'd0, tv0}, 32'd1);
      if (k == 3)  check("t2.xyz_c3", {29'd0, x1, y1, z1}, 32'd1);
      if (k == 16) check("t2.xyz_c16", {29'd0, x1, y1, z1}, 32'd7);
      if (k == 17) check("t2.xyz_c17", {29'd0, x1, y1, z1}, 32'd0);
      start = (k == 5 || k == 24 || k == 25);
      @(negedge clk);
    end
    start = 1'b0;
    check("t1.done_cycle", 32'(dk0), 32'd25);
    check("t3.done_count", 32'(nd0), 32'd1);
    check("t2.done_cycle_h1", 32'(dk1), 32'd17);
    check("t1.table", {24'd0, tt0}, 32'h96);
    wait_idle();

    // Reset mid-sweep while vector 3 is driven.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ({x0, y0, z0} == 3'd3) break;
      @(negedge clk);
    end
    check("t4.reached_idx3", {29'd0, x0, y0, z0}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4.xyz", {29'd0, x0, y0, z0}, 32'd0);
    check("t4.busy_done_valid", {29'd0, busy0, done0, tv0}, 32'd0);
    check("t4.table", {24'd0, tt0}, 32'h00);
    sweep();
    check("t4.fresh_table", {24'd0, tt0}, 32'h96);

    // Constant F.
    ftab = 8'hFF;
    sweep();
    check("t5.ones", {24'd0, tt0}, 32'hFF);
    check("t5.ones_h1", {24'd0, tt1}, 32'hFF);
    ftab = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5.valid_drop", {31'd0, tv0}, 32'd0);
    wait_idle();
    check("t5.zeros", {24'd0, tt0}, 32'h00);

`ifdef FXYZ_SWEEP_CHECK_EN
    ftab = 8'h96;
    sweep();
    check("t6.mis_xor", {31'd0, mis0}, 32'd0);
    ftab = 8'h80;  // F = X&Y&Z
    sweep();
    check("t6.mis_and", {31'd0, mis0}, 32'd1);
    repeat (3) @(negedge clk);
    check("t6.mis_hold", {31'd0, mis0}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6.mis_clear", {31'd0, mis0}, 32'd0);
    wait_idle();
`endif

    // start held high: one sweep per IDLE visit.
    ftab = 8'h5A;
    start = 1'b1;
    repeat (60) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random tables, start patterns and occasional resets.
    for (int it = 0; it < 30; it++) begin
      ftab = 8'($urandom);
      for (int c = 0; c < 40; c++) begin
        start = ($urandom_range(7) == 0);
        rst   = ($urandom_range(60) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      wait_idle();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
